// File: rtl/ac97_sample_scheduler.sv
// rtl/ac97_sample_scheduler.sv - AC97 playback sample FIFO with prime/play/underrun scheduling
module ac97_sample_scheduler #(
  parameter int         DEPTH_LOG2  = 4,
  parameter int         PRIME_LEVEL = 8,
  parameter logic [7:0] IDLE_VALUE  = 8'h80
) (
  input  logic                  sys_clk,
  input  logic                  reset_b,
  input  logic                  enable,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  input  logic                  ready,
  output logic [7:0]            audio_out_data,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [1:0]            state,
  output logic [15:0]           underrun_count
);

  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL       = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   PRIME_FILL = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0]   FILL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_t;

  state_t                cur_state;
  logic                  armed;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            mem [DEPTH];
  logic                  do_wr;
  logic                  frame_in_play;
  logic                  do_pop;
  logic                  underrun;

  assign state         = cur_state;
  assign wr_ready      = (cur_state != ST_IDLE) && (fill_level < FULL);
  assign do_wr         = armed && enable && wr_valid && wr_ready;
  assign frame_in_play = armed && enable && ready && (cur_state == ST_PLAY);
  assign do_pop        = frame_in_play && (fill_level != '0);
  assign underrun      = frame_in_play && (fill_level == '0);

  always_ff @(posedge sys_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // armed swallows the first edge after reset release so nothing moves on it
  always_ff @(posedge sys_clk or negedge reset_b) begin
    if (!reset_b) begin
      cur_state      <= ST_IDLE;
      armed          <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      audio_out_data <= IDLE_VALUE;
      underrun_count <= 16'd0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (!enable) begin
      cur_state      <= ST_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      audio_out_data <= IDLE_VALUE;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr         <= rd_ptr + PTR_ONE;
        audio_out_data <= mem[rd_ptr];
      end
      if (do_wr && !do_pop)      fill_level <= fill_level + FILL_ONE;
      else if (do_pop && !do_wr) fill_level <= fill_level - FILL_ONE;

      case (cur_state)
        ST_IDLE:  cur_state <= ST_PRIME;
        ST_PRIME: if (fill_level >= PRIME_FILL) cur_state <= ST_PLAY;
        ST_PLAY: begin
          if (underrun) begin
            cur_state      <= ST_UNDERRUN;
            audio_out_data <= IDLE_VALUE;
            if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
          end
        end
        ST_UNDERRUN: if (fill_level >= PRIME_FILL) cur_state <= ST_PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_ac97_sample_scheduler.sv
// tb/tb_ac97_sample_scheduler.sv - scoreboard bench for ac97_sample_scheduler
module tb_ac97_sample_scheduler;

  logic        sys_clk = 1'b0;
  logic        reset_b;
  logic        enable;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        ready;
  logic [7:0]  audio_out_data;
  logic [4:0]  fill_level;
  logic [1:0]  state;
  logic [15:0] underrun_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  int         exp_fill  = 0;
  int         exp_st    = 0;
  int         exp_cnt   = 0;
  logic [7:0] exp_audio = 8'h80;

  ac97_sample_scheduler dut (
    .sys_clk        (sys_clk),
    .reset_b        (reset_b),
    .enable         (enable),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .ready          (ready),
    .audio_out_data (audio_out_data),
    .fill_level     (fill_level),
    .state          (state),
    .underrun_count (underrun_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model predicts the post-edge outputs independently.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd);
    bit exp_rdy, acc, pop, urun;
    int old_fill, old_st;
    wr_valid = wr;
    wr_data  = d;
    ready    = rd;
    old_fill = exp_fill;
    old_st   = exp_st;
    exp_rdy  = (old_st != 0) && (old_fill < 16);
    check("wr_ready", {31'd0, wr_ready}, {31'd0, exp_rdy});
    acc  = enable && wr && exp_rdy;
    pop  = enable && rd && old_st == 2 && old_fill > 0;
    urun = enable && rd && old_st == 2 && old_fill == 0;
    @(posedge sys_clk);
    #1;
    if (!enable) begin
      exp_st    = 0;
      exp_fill  = 0;
      exp_audio = 8'h80;
      sb_q.delete();
    end else begin
      if (pop) exp_audio = sb_q.pop_front();
      if (acc) sb_q.push_back(d);
      exp_fill = old_fill + (acc ? 1 : 0) - (pop ? 1 : 0);
      case (old_st)
        0: exp_st = 1;
        1: if (old_fill >= 8) exp_st = 2;
        2: if (urun) begin
             exp_st    = 3;
             exp_audio = 8'h80;
             if (exp_cnt != 16'hFFFF) exp_cnt++;
           end
        3: if (old_fill >= 8) exp_st = 2;
        default: exp_st = 0;
      endcase
    end
    check("state", {30'd0, state}, exp_st);
    check("fill_level", {27'd0, fill_level}, exp_fill);
    check("audio_out_data", {24'd0, audio_out_data}, {24'd0, exp_audio});
    check("underrun_count", {16'd0, underrun_count}, exp_cnt);
    wr_valid = 1'b0;
    ready    = 1'b0;
  endtask

  initial begin
    reset_b  = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    ready    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_state", {30'd0, state}, 0);
    check("rst_fill", {27'd0, fill_level}, 0);
    check("rst_audio", {24'd0, audio_out_data}, 32'h80);
    check("rst_count", {16'd0, underrun_count}, 0);
    check("rst_wr_ready", {31'd0, wr_ready}, 0);

    // release between edges with enable already high: first edge must do nothing
    reset_b = 1'b1;
    enable  = 1'b1;
    @(posedge sys_clk);
    #1;
    check("arm_edge_state", {30'd0, state}, 0);
    check("arm_edge_fill", {27'd0, fill_level}, 0);

    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("play_after_prime", {30'd0, state}, 2);

    repeat (3) begin
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
    end
    check("fill_after_3_pops", {27'd0, fill_level}, 5);

    repeat (5) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("underrun_state", {30'd0, state}, 3);
    repeat (2) step(1'b0, 8'h00, 1'b1);
    check("underrun_once", {16'd0, underrun_count}, 1);

    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("replay", {30'd0, state}, 2);

    for (int i = 0; i < 10; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    check("sat_fill", {27'd0, fill_level}, 16);
    step(1'b1, 8'h3A, 1'b1);
    step(1'b1, 8'h3B, 1'b1);
    step(1'b1, 8'h3C, 1'b0);
    check("refull", {27'd0, fill_level}, 16);

    repeat (10) step(1'b0, 8'h00, 1'b1);
    check("fill_before_flush", {27'd0, fill_level}, 6);
    enable = 1'b0;
    step(1'b1, 8'h55, 1'b1);
    check("flush_count_kept", {16'd0, underrun_count}, 1);
    enable = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    #2;
    reset_b = 1'b0;
    #1;
    check("async_state", {30'd0, state}, 0);
    check("async_fill", {27'd0, fill_level}, 0);
    check("async_audio", {24'd0, audio_out_data}, 32'h80);
    check("async_count", {16'd0, underrun_count}, 0);
    check("async_wr_ready", {31'd0, wr_ready}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
